// File: rtl/audio_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fmt_pkg
//  Brief    : Shared audio sample-format helpers: saturation limits and the
//             first-stage record of the narrowing pipeline.
//  Revision : 1.0  initial release
// ============================================================================
package audio_fmt_pkg;

    // Container width for the stage-1 value; covers L_WD up to 32 (W = L_WD+2).
    localparam int unsigned c_y_w   = 34;
    // Width used for limit arithmetic; wide enough for any supported S_WD.
    localparam int unsigned c_lim_w = 64;

    // Stage-1 record: rounded/shifted value (sign-extended), signedness, valid.
    typedef struct packed {
        logic signed [c_y_w-1:0] y;
        logic                    is_signed;
        logic                    valid;
    } s1_rec_t;

    // Largest representable value of a width-bit signed or unsigned sample.
    function automatic logic signed [c_lim_w-1:0] sat_max(input int unsigned width,
                                                          input logic        is_signed);
        return is_signed ? ((64'sd1 <<< (width - 1)) - 64'sd1)
                         : ((64'sd1 <<< width) - 64'sd1);
    endfunction

    // Smallest representable value of a width-bit signed or unsigned sample.
    function automatic logic signed [c_lim_w-1:0] sat_min(input int unsigned width,
                                                          input logic        is_signed);
        return is_signed ? (-(64'sd1 <<< (width - 1))) : 64'sd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_data_extend.sv
`default_nettype none
// ============================================================================
//  Module   : signed_data_extend
//  Brief    : Widens an S_WD-bit sample to L_WD bits, sign- or zero-extending
//             according to signed_i.
//  Revision : 1.0  initial release
// ============================================================================
module signed_data_extend #(
    parameter int unsigned S_WD = 8,
    parameter int unsigned L_WD = 16
) (
    input  logic [S_WD-1:0] data_i,
    input  logic            signed_i,
    output logic [L_WD-1:0] data_o
);

    // Replicate the MSB only for two's-complement input.
    assign data_o = {{(L_WD - S_WD){signed_i & data_i[S_WD-1]}}, data_i};

endmodule
`default_nettype wire

// File: rtl/signed_data_narrow.sv
`default_nettype none
// ============================================================================
//  Module   : signed_data_narrow
//  Brief    : Streaming saturating narrower L_WD -> S_WD with optional
//             right-shift and round-half-up, valid/ready on both sides and a
//             saturating clip counter for gain monitoring.
//  Revision : 1.0  initial release
// ============================================================================
module signed_data_narrow
    import audio_fmt_pkg::*;
#(
    parameter  int unsigned L_WD   = 16,
    parameter  int unsigned S_WD   = 8,
    parameter  int unsigned CNT_WD = 16,
    localparam int unsigned SH_WD  = $clog2(L_WD - S_WD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [L_WD-1:0]   data_i,
    input  logic              signed_i,
    input  logic [SH_WD-1:0]  shift_i,
    input  logic              round_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [S_WD-1:0]   data_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              clr_i,
    output logic              clip_o,
    output logic [CNT_WD-1:0] clip_cnt_o
);

    // Internal width: two guard bits so rounding of an unsigned full-scale
    // value cannot overflow into the sign.
    localparam int unsigned c_w      = L_WD + 2;
    localparam int unsigned c_max_sh = L_WD - S_WD;

    // ------------------------------------------------------------------
    // Stage-1 datapath: widen, round, shift
    // ------------------------------------------------------------------
    logic        [c_w-1:0]   w_x_raw;
    logic        [SH_WD-1:0] w_sh;
    logic signed [c_w-1:0]   w_r;
    logic signed [c_w-1:0]   w_sum;
    logic signed [c_w-1:0]   w_y;

    signed_data_extend #(
        .S_WD (L_WD),
        .L_WD (c_w)
    ) u_extend (
        .data_i   (data_i),
        .signed_i (signed_i),
        .data_o   (w_x_raw)
    );

    // Clamp the shift, add the half-LSB rounding constant, arithmetic shift.
    always_comb begin
        w_sh = (shift_i > SH_WD'(c_max_sh)) ? SH_WD'(c_max_sh) : shift_i;
        w_r  = '0;
        if (round_i && (w_sh != '0)) begin
            w_r[w_sh - SH_WD'(1)] = 1'b1;
        end
        w_sum = $signed(w_x_raw) + w_r;
        w_y   = w_sum >>> w_sh;
    end

    // ------------------------------------------------------------------
    // Handshake: each stage advances when empty or when its successor does
    // ------------------------------------------------------------------
    s1_rec_t             s1_q, s1_d;
    logic [S_WD-1:0]     data_q, data_d;
    logic                valid_q, valid_d;
    logic                clip_q, clip_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;

    logic w_s1_adv;
    logic w_s1_load;
    logic w_accept;

    assign w_s1_adv  = !valid_q | ready_i;
    assign w_s1_load = !s1_q.valid | w_s1_adv;
    assign ready_o   = rst_ni & w_s1_load;
    assign w_accept  = valid_i & ready_o;

    // Next stage-1 record: capture the sample and its controls on accept.
    always_comb begin
        s1_d = s1_q;
        if (w_s1_load) begin
            s1_d.valid = w_accept;
            if (w_accept) begin
                s1_d.y         = c_y_w'(w_y);
                s1_d.is_signed = signed_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage-2 datapath: clamp to the output range and detect clipping
    // ------------------------------------------------------------------
    logic signed [c_y_w-1:0]   w_y1;
    logic signed [c_lim_w-1:0] w_y_ext;
    logic signed [c_lim_w-1:0] w_max;
    logic signed [c_lim_w-1:0] w_min;
    logic        [S_WD-1:0]    w_sat;
    logic                      w_clamp;
    logic                      w_clip_evt;
    logic        [CNT_WD-1:0]  w_cnt_base;

    assign w_y1    = $signed(s1_q.y);
    assign w_y_ext = {{(c_lim_w - c_y_w){w_y1[c_y_w-1]}}, w_y1};
    assign w_max   = sat_max(S_WD, s1_q.is_signed);
    assign w_min   = sat_min(S_WD, s1_q.is_signed);

    // Saturate against the format limits and flag when the clamp fires.
    always_comb begin
        w_sat   = w_y_ext[S_WD-1:0];
        w_clamp = 1'b0;
        if (w_y_ext > w_max) begin
            w_sat   = w_max[S_WD-1:0];
            w_clamp = 1'b1;
        end else if (w_y_ext < w_min) begin
            w_sat   = w_min[S_WD-1:0];
            w_clamp = 1'b1;
        end
    end

    assign w_clip_evt = w_s1_adv & s1_q.valid & w_clamp;
    assign w_cnt_base = clr_i ? '0 : cnt_q;

    // Output register and clip bookkeeping; clear applies before counting.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (w_s1_adv) begin
            valid_d = s1_q.valid;
            if (s1_q.valid) begin
                data_d = w_sat;
            end
        end
        cnt_d = w_cnt_base;
        if (w_clip_evt && (w_cnt_base != '1)) begin
            cnt_d = w_cnt_base + CNT_WD'(1);
        end
        clip_d = (clip_q & !clr_i) | w_clip_evt;
    end

    // All pipeline and status state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign clip_o     = clip_q;
    assign clip_cnt_o = cnt_q;

endmodule
`default_nettype wire
